// File: rtl/irq_pending_latch.sv
// Request-capture stage: latches rising edges of irq_in into pending bits until acked.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchroniser per line ahead of edge detect.
module irq_pending_latch #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         irq_in,
  input  logic [N-1:0]         mask,
  input  logic                 ack_valid,
  input  logic [$clog2(N)-1:0] ack_idx,
  input  logic                 lost_clr,
  output logic [N-1:0]         req_out,
  output logic                 irq_out,
  output logic [N-1:0]         pending,
  output logic [N-1:0]         lost
);

  localparam int IW = $clog2(N);

  logic [N-1:0] s_s;
  logic [N-1:0] prev_q;
  logic [N-1:0] prev_d;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [N-1:0] lost_q;
  logic [N-1:0] lost_d;
  logic [N-1:0] rise_s;
  logic [N-1:0] clr_s;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  // Two-stage synchroniser for asynchronous request lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {N{1'b0}};
      sync2_q <= {N{1'b0}};
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign s_s = sync2_q;
`else
  assign s_s = irq_in;
`endif

  // Ack decode; indices >= N match no line and are therefore ignored
  always_comb begin
    clr_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (ack_valid && (ack_idx == IW'(i))) begin
        clr_s[i] = 1'b1;
      end else begin
        clr_s[i] = 1'b0;
      end
    end
  end

  // Edge detect plus pending/lost next-state; a new edge beats a same-cycle ack
  always_comb begin
    rise_s    = s_s & ~prev_q;
    prev_d    = s_s;
    pending_d = rise_s | (pending_q & ~clr_s);
    if (lost_clr) begin
      lost_d = {N{1'b0}};
    end else begin
      lost_d = lost_q | (rise_s & pending_q & ~clr_s);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= {N{1'b0}};
      pending_q <= {N{1'b0}};
      lost_q    <= {N{1'b0}};
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  assign pending = pending_q;
  assign lost    = lost_q;
  assign req_out = pending_q & mask;
  assign irq_out = |req_out;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Table-driven scoreboard bench for irq_pending_latch (N=4).
module tb_irq_pending_latch;

  logic       clk;
  logic       rst;
  logic [3:0] irq_in;
  logic [3:0] mask;
  logic       ack_valid;
  logic [1:0] ack_idx;
  logic       lost_clr;
  logic [3:0] req_out;
  logic       irq_out;
  logic [3:0] pending;
  logic [3:0] lost;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] irq;
    logic [3:0] msk;
    logic       av;
    logic [1:0] idx;
    logic       lclr;
    logic [3:0] pend;
    logic [3:0] lst;
    logic [3:0] req;
    logic       irqo;
  } vec_t;

  vec_t vecs[24];
  vec_t exp_q[$];

  irq_pending_latch #(.N(4)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .lost_clr(lost_clr),
    .req_out(req_out), .irq_out(irq_out), .pending(pending), .lost(lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] irq, input logic [3:0] msk, input logic av,
                              input logic [1:0] idx, input logic lclr, input logic [3:0] pend,
                              input logic [3:0] lst, input logic [3:0] req, input logic irqo);
    vec_t v;
    v.irq = irq; v.msk = msk; v.av = av; v.idx = idx; v.lclr = lclr;
    v.pend = pend; v.lst = lst; v.req = req; v.irqo = irqo;
    return v;
  endfunction

  // Drive one row at negedge, push its expectation, compare #1 after the edge.
  task automatic apply(input vec_t v, input int row);
    vec_t e;
    @(negedge clk);
    irq_in = v.irq; mask = v.msk; ack_valid = v.av; ack_idx = v.idx; lost_clr = v.lclr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("row%0d_pending", row), pending, e.pend);
    chk($sformatf("row%0d_lost", row), lost, e.lst);
    chk($sformatf("row%0d_req", row), req_out, e.req);
    chk($sformatf("row%0d_irq", row), {3'b000, irq_out}, {3'b000, e.irqo});
  endtask

  task automatic idle_in();
    irq_in = 4'b0000; mask = 4'b1111; ack_valid = 1'b0; ack_idx = 2'd0; lost_clr = 1'b0;
  endtask

  initial begin
    //             irq      mask     av    idx    lclr  pend     lost     req      irq
    vecs[0]  = mk(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vecs[1]  = mk(4'b0100, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1);
    vecs[2]  = mk(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1);
    vecs[3]  = mk(4'b0000, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vecs[4]  = mk(4'b0000, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vecs[5]  = mk(4'b0010, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1);
    vecs[6]  = mk(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1);
    vecs[7]  = mk(4'b0010, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1);
    vecs[8]  = mk(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1);
    vecs[9]  = mk(4'b0010, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1);
    vecs[10] = mk(4'b0000, 4'b1111, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vecs[11] = mk(4'b0001, 4'b1110, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    vecs[12] = mk(4'b0000, 4'b1110, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    vecs[13] = mk(4'b0000, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vecs[14] = mk(4'b1000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b1);
    vecs[15] = mk(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b1);
    vecs[16] = mk(4'b1000, 4'b1111, 1'b1, 2'd3, 1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b1);
    vecs[17] = mk(4'b0000, 4'b1111, 1'b1, 2'd3, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vecs[18] = mk(4'b0101, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0101, 4'b0000, 4'b0101, 1'b1);
    vecs[19] = mk(4'b0000, 4'b1111, 1'b1, 2'd1, 1'b0, 4'b0101, 4'b0000, 4'b0101, 1'b1);
    vecs[20] = mk(4'b1010, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1);
    vecs[21] = mk(4'b0000, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b1110, 4'b0000, 4'b1110, 1'b1);
    vecs[22] = mk(4'b0000, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b1010, 4'b0000, 4'b1010, 1'b1);
    vecs[23] = mk(4'b0010, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b1010, 4'b0010, 4'b1010, 1'b1);

    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pending", pending, 4'b0000);
    chk("reset_lost", lost, 4'b0000);
    chk("reset_req", req_out, 4'b0000);
    chk("reset_irq", {3'b000, irq_out}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

`ifndef IRQ_SYNC_EN
    for (int r = 0; r < 13; r++) apply(vecs[r], r);

    // Unmasking exposes the held pending bit without a clock edge.
    @(negedge clk);
    mask = 4'b1111;
    #1;
    chk("unmask_req", req_out, 4'b0001);
    chk("unmask_irq", {3'b000, irq_out}, 4'b0001);

    for (int r = 13; r < 24; r++) apply(vecs[r], r);

    // Asynchronous reset mid-operation with pending=1010, lost=0010.
    @(negedge clk);
    idle_in();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_pending", pending, 4'b0000);
    chk("midrst_lost", lost, 4'b0000);
    chk("midrst_req", req_out, 4'b0000);
    chk("midrst_irq", {3'b000, irq_out}, 4'b0000);

    // Lines held high across reset release yield exactly one capture.
    irq_in = 4'b1111;
    @(posedge clk);
    #1;
    chk("held_in_reset", pending, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("held_first", pending, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ack_valid = 1'b1;
      ack_idx = 2'(k);
    end
    @(negedge clk);
    ack_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("held_once_pending", pending, 4'b0000);
    chk("held_once_lost", lost, 4'b0000);
`else
    // Synchronised capture: rise on line 1 lands in pending on the third edge.
    @(negedge clk);
    irq_in = 4'b0010;
    @(posedge clk);
    #1;
    chk("sync_edge1", pending, 4'b0000);
    @(posedge clk);
    #1;
    chk("sync_edge2", pending, 4'b0000);
    @(posedge clk);
    #1;
    chk("sync_edge3", pending, 4'b0010);
    chk("sync_irq", {3'b000, irq_out}, 4'b0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream request-capture stage for the 4-to-2 priority encoder.
- Detects rising edges on raw request lines and holds each event in a pending bit until it is acknowledged.
- Presents the masked pending vector as the encoder's request input.
- Downstream logic returns the encoded index on an ack strobe, which clears that pending bit.

Parameters:
- N, 4, number of request lines. Legal range is 2 to 16.
- IW, derived localparam = $clog2(N), width of the ack index. Not overridable.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- irq_in  in  N  raw level request lines
- mask  in  N  per-line enable; 1 = line visible on req_out
- ack_valid  in  1  single-cycle strobe: clear pending bit ack_idx
- ack_idx  in  IW  index of the line to clear (encoder y output)
- lost_clr  in  1  clears all sticky lost bits
- req_out  out  N  pending & mask; drives the encoder's request input
- irq_out  out  1  OR-reduction of req_out
- pending  out  N  raw pending register, unmasked
- lost  out  N  sticky flag per line: an edge arrived while that line was already pending

Behaviour:
- Reset: prev, pending and lost all clear to 0. Therefore req_out=0, irq_out=0 and lost=0 during and after reset.
- Edge detect:
  - rise[i] = s[i] & ~prev[i], where s is irq_in, or its synchronised copy when the optional feature is enabled.
  - prev <= s every cycle.
  - prev resets to 0, so a line already high at reset release produces exactly one edge.
- Pending update, per bit i, each cycle:
  - clr[i] = ack_valid & (ack_idx == i).
  - pending[i] <= rise[i] | (pending[i] & ~clr[i]).
  - A simultaneous rise and ack on the same bit leaves the bit set: the new event wins, and lost is not set.
- Lost:
  - lost[i] <= lost_clr ? 0 : lost[i] | (rise[i] & pending[i] & ~clr[i]).
  - lost_clr has priority, and the same-cycle lost event is discarded.
- Masking:
  - The mask affects only req_out and irq_out. Capture continues while a line is masked.
  - Unmasking exposes a held pending bit combinationally in the same cycle.
- ack_idx >= N: ignored, no state change. This can only occur when N is not a power of 2.
- ack_valid on a bit that is not pending: no effect.
- Latency:
  - With the optional feature off, irq_in rising at edge t sets pending at edge t+1.
  - req_out and irq_out are combinational from registers, so they are valid in the cycle after capture.
  - An ack at edge t clears the bit after edge t.
- Multiple simultaneous edges are all captured in the same cycle.
- Reset mid-operation: all pending events and lost flags are lost immediately (asynchronous). No ack is needed afterwards.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined:
  - irq_in passes through a 2-flop synchroniser per bit before edge detect. Both flops reset to 0.
  - Capture latency rises to 3 edges.
- Undefined:
  - irq_in feeds edge detect directly. It must be synchronous to clk.
  - Latency is 1 edge.

Test Plan:
- Reset with irq_in=4'b0000, release, then pulse irq_in[2] for 1 cycle -> pending=4'b0100 one edge later; req_out=4'b0100; irq_out=1.
- pending=4'b0100, ack_valid=1, ack_idx=2 -> pending=4'b0000 and irq_out=0 next cycle. A repeated ack produces no change.
- Two rises on line 1 with no ack in between -> lost=4'b0010. lost_clr=1 -> lost=4'b0000. Raising lost_clr together with a new overflow still gives lost=0.
- mask=4'b1110, pulse irq_in[0] -> pending=4'b0001, req_out=4'b0000, irq_out=0. Setting mask=4'b1111 -> req_out=4'b0001 in the same cycle.
- pending[3]=1, rise on line 3 in the same cycle as ack_idx=3 -> pending[3] stays 1 and lost[3] stays 0. irq_in=4'b1111 held across reset release -> pending=4'b1111 exactly once.
- Assert rst mid-operation with pending=4'b1010 and lost=4'b0010 -> all outputs 0 immediately. With IRQ_SYNC_EN defined, a rise on irq_in[1] appears in pending after 3 edges.
